// File: rtl/multi_cycle_shifter.sv
// Iterative logarithmic shifter: one barrel stage (shift by 2^k) per clock,
// with a start/ready handshake and a one-cycle result-valid pulse.
module multi_cycle_shifter #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               ctrl_start,
    input  logic [1:0]         ctrl_mode,
    input  logic [SHAMT_W-1:0] ctrl_shiftamt,
    input  logic [WIDTH-1:0]   data_operandA,
    output logic               ready,
    output logic               data_resultRDY,
    output logic [WIDTH-1:0]   data_result
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    typedef enum logic [1:0] {
        MODE_SLL = 2'b00,
        MODE_SRL = 2'b01,
        MODE_SRA = 2'b10,
        MODE_ROL = 2'b11
    } mode_t;

    localparam logic [SHAMT_W-1:0] K_LAST = SHAMT_W'(SHAMT_W - 1);

    state_t             state;
    state_t             state_next;
    mode_t              mode_q;
    logic [SHAMT_W-1:0] shamt_q;
    logic [SHAMT_W-1:0] k;
    logic [WIDTH-1:0]   work;
    logic [WIDTH-1:0]   stage_out;
    logic               accept;
    logic               last_stage;
    logic               stage_en;

    // One barrel stage; amt is always a power of two below WIDTH.
    function automatic logic [WIDTH-1:0] stage_shift(
        input logic [WIDTH-1:0] w,
        input mode_t            m,
        input int               amt
    );
        logic [WIDTH-1:0] r;
        case (m)
            MODE_SLL: r = w << amt;
            MODE_SRL: r = w >> amt;
            MODE_SRA: r = $signed(w) >>> amt;
            default:  r = (w << amt) | (w >> (WIDTH - amt));
        endcase
        return r;
    endfunction

    assign accept     = ctrl_start && (state != SHIFT);
    assign last_stage = (k == K_LAST);
    assign stage_en   = |(shamt_q & (SHAMT_W'(1) << k));

    always_comb begin
        stage_out = work;
        if (stage_en) begin
            stage_out = stage_shift(work, mode_q, 32'd1 << k);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent simulation.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: state_next gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (ctrl_start) state_next = SHIFT;
            SHIFT:   if (last_stage) state_next = DONE;
            DONE:    state_next = ctrl_start ? SHIFT : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            work    <= '0;
            k       <= '0;
            shamt_q <= '0;
            mode_q  <= MODE_SLL;
        end else if (accept) begin
            work    <= data_operandA;
            k       <= '0;
            shamt_q <= ctrl_shiftamt;
            mode_q  <= mode_t'(ctrl_mode);
        end else if (state == SHIFT) begin
            work <= stage_out;
            k    <= last_stage ? '0 : k + 1'b1;
        end
    end

    // Everything below decodes registered state only.
    assign ready          = (state != SHIFT);
    assign data_resultRDY = (state == DONE);
    assign data_result    = work;

endmodule

// File: tb/tb_multi_cycle_shifter.sv
// Directed, table-driven bench for multi_cycle_shifter at WIDTH=32 and WIDTH=8,
// plus hand-written back-to-back, ignored-start and mid-operation reset sequences.
module tb_multi_cycle_shifter;

    localparam logic [1:0] SLL = 2'b00;
    localparam logic [1:0] SRL = 2'b01;
    localparam logic [1:0] SRA = 2'b10;
    localparam logic [1:0] ROL = 2'b11;

    typedef struct {
        logic [1:0]  mode;
        logic [4:0]  shamt;
        logic [31:0] operand;
        logic [31:0] expected;
    } vec_t;

    logic        clock = 1'b0;
    logic        reset_n;

    logic        start32;
    logic [1:0]  mode32;
    logic [4:0]  shamt32;
    logic [31:0] op32;
    logic        ready32;
    logic        rdy32;
    logic [31:0] res32;

    logic        start8;
    logic [1:0]  mode8;
    logic [2:0]  shamt8;
    logic [7:0]  op8;
    logic        ready8;
    logic        rdy8;
    logic [7:0]  res8;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    multi_cycle_shifter #(.WIDTH(32)) dut32 (
        .clock          (clock),
        .reset_n        (reset_n),
        .ctrl_start     (start32),
        .ctrl_mode      (mode32),
        .ctrl_shiftamt  (shamt32),
        .data_operandA  (op32),
        .ready          (ready32),
        .data_resultRDY (rdy32),
        .data_result    (res32)
    );

    multi_cycle_shifter #(.WIDTH(8)) dut8 (
        .clock          (clock),
        .reset_n        (reset_n),
        .ctrl_start     (start8),
        .ctrl_mode      (mode8),
        .ctrl_shiftamt  (shamt8),
        .data_operandA  (op8),
        .ready          (ready8),
        .data_resultRDY (rdy8),
        .data_result    (res8)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Call at a negedge; returns #1 after the accepting edge with start dropped.
    task automatic launch32(input logic [1:0] m, input logic [4:0] s, input logic [31:0] a);
        start32 = 1'b1;
        mode32  = m;
        shamt32 = s;
        op32    = a;
        @(posedge clock);
        #1;
        start32 = 1'b0;
        mode32  = 2'($urandom);
        shamt32 = 5'($urandom);
        op32    = $urandom;
    endtask

    // Latency counts the accept cycle as 1; ready_bad flags ready=1 during SHIFT.
    task automatic wait_rdy32(output int lat, output bit seen, output bit ready_bad);
        lat       = 1;
        seen      = 1'b0;
        ready_bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (rdy32) begin
                seen = 1'b1;
                break;
            end
            if (ready32) ready_bad = 1'b1;
            @(posedge clock);
            lat++;
        end
    endtask

    task automatic run8(input logic [1:0] m, input logic [2:0] s, input logic [7:0] a,
                        output logic [7:0] r, output int lat, output bit seen);
        start8 = 1'b1;
        mode8  = m;
        shamt8 = s;
        op8    = a;
        @(posedge clock);
        #1;
        start8 = 1'b0;
        op8    = 8'($urandom);
        lat    = 1;
        seen   = 1'b0;
        r      = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (rdy8) begin
                seen = 1'b1;
                r    = res8;
                break;
            end
            @(posedge clock);
            lat++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs[10];
        vec_t        vecs8[4];
        int          lat;
        bit          seen;
        bit          ready_bad;
        int          pulses;
        logic [7:0]  r8;

        vecs[0] = '{SLL, 5'd16, 32'h0000ABCD, 32'hABCD0000};
        vecs[1] = '{SRA, 5'd31, 32'h80000000, 32'hFFFFFFFF};
        vecs[2] = '{SRL, 5'd31, 32'h80000000, 32'h00000001};
        vecs[3] = '{ROL, 5'd4,  32'h80000001, 32'h00000018};
        vecs[4] = '{SRA, 5'd0,  32'h12345678, 32'h12345678};
        vecs[5] = '{SLL, 5'd31, 32'h00000001, 32'h80000000};
        vecs[6] = '{ROL, 5'd8,  32'h12345678, 32'h34567812};
        vecs[7] = '{SRA, 5'd5,  32'h7FFFFFFF, 32'h03FFFFFF};
        vecs[8] = '{SRL, 5'd4,  32'hDEADBEEF, 32'h0DEADBEE};
        vecs[9] = '{SRA, 5'd4,  32'hF0000000, 32'hFF000000};

        vecs8[0] = '{SRA, 5'd3, 32'h90, 32'hF2};
        vecs8[1] = '{ROL, 5'd7, 32'h81, 32'hC0};
        vecs8[2] = '{SRL, 5'd7, 32'h80, 32'h01};
        vecs8[3] = '{SLL, 5'd5, 32'h03, 32'h60};

        start32 = 1'b0; mode32 = SLL; shamt32 = '0; op32 = '0;
        start8  = 1'b0; mode8  = SLL; shamt8  = '0; op8  = '0;
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        #2;
        check("reset_ready", 32'(ready32), 32'd1);
        check("reset_rdy", 32'(rdy32), 32'd0);
        check("reset_result", res32, 32'd0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        check("post_reset_ready", 32'(ready32), 32'd1);
        check("post_reset_result", res32, 32'd0);

        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            check($sformatf("v%0d_ready_idle", i), 32'(ready32), 32'd1);
            launch32(vecs[i].mode, vecs[i].shamt, vecs[i].operand);
            wait_rdy32(lat, seen, ready_bad);
            check($sformatf("v%0d_seen", i), 32'(seen), 32'd1);
            check($sformatf("v%0d_latency", i), 32'(lat), 32'd6);
            check($sformatf("v%0d_result", i), res32, vecs[i].expected);
            check($sformatf("v%0d_ready_low", i), 32'(ready_bad), 32'd0);
            check($sformatf("v%0d_ready_done", i), 32'(ready32), 32'd1);
            @(negedge clock);
            check($sformatf("v%0d_pulse_end", i), 32'(rdy32), 32'd0);
            check($sformatf("v%0d_result_hold", i), res32, vecs[i].expected);
        end

        // Back-to-back: second start issued in the DONE cycle.
        @(negedge clock);
        launch32(ROL, 5'd8, 32'h12345678);
        wait_rdy32(lat, seen, ready_bad);
        check("b2b_first_result", res32, 32'h34567812);
        check("b2b_done_ready", 32'(ready32), 32'd1);
        launch32(SRL, 5'd8, 32'hF0000000);
        wait_rdy32(lat, seen, ready_bad);
        check("b2b_seen", 32'(seen), 32'd1);
        check("b2b_pulse_gap", 32'(lat), 32'd6);
        check("b2b_second_result", res32, 32'h00F00000);
        @(negedge clock);
        check("b2b_pulse_end", 32'(rdy32), 32'd0);

        // Start held high with changing inputs throughout SHIFT.
        @(negedge clock);
        launch32(SRL, 5'd12, 32'hDEADBEEF);
        lat  = 1;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (rdy32) begin
                seen    = 1'b1;
                start32 = 1'b0;
                break;
            end
            start32 = 1'b1;
            mode32  = 2'($urandom);
            shamt32 = 5'($urandom);
            op32    = $urandom;
            @(posedge clock);
            lat++;
        end
        check("ign_seen", 32'(seen), 32'd1);
        check("ign_latency", 32'(lat), 32'd6);
        check("ign_result", res32, 32'h000DEADB);
        pulses = 0;
        repeat (12) begin
            @(negedge clock);
            if (rdy32) pulses++;
        end
        check("ign_extra_pulses", 32'(pulses), 32'd0);

        // Reset asserted during stage 2.
        @(negedge clock);
        launch32(SLL, 5'd3, 32'h0000FFFF);
        @(posedge clock);
        @(posedge clock);
        #2 reset_n = 1'b0;
        #1;
        check("rst_mid_ready", 32'(ready32), 32'd1);
        check("rst_mid_rdy", 32'(rdy32), 32'd0);
        check("rst_mid_result", res32, 32'd0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        pulses = 0;
        repeat (10) begin
            @(negedge clock);
            if (rdy32) pulses++;
        end
        check("rst_mid_no_pulse", 32'(pulses), 32'd0);
        launch32(SLL, 5'd16, 32'h0000ABCD);
        wait_rdy32(lat, seen, ready_bad);
        check("rst_fresh_latency", 32'(lat), 32'd6);
        check("rst_fresh_result", res32, 32'hABCD0000);

        // Narrow instance.
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            check($sformatf("w8_v%0d_ready", i), 32'(ready8), 32'd1);
            run8(vecs8[i].mode, vecs8[i].shamt[2:0], vecs8[i].operand[7:0], r8, lat, seen);
            check($sformatf("w8_v%0d_seen", i), 32'(seen), 32'd1);
            check($sformatf("w8_v%0d_latency", i), 32'(lat), 32'd4);
            check($sformatf("w8_v%0d_result", i), 32'(r8), vecs8[i].expected);
            @(negedge clock);
            check($sformatf("w8_v%0d_pulse_end", i), 32'(rdy8), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multi_cycle_shifter.md
# multi_cycle_shifter

Parametrised, iterative logarithmic shifter for the ALU datapath. It supports logical-left, logical-right, arithmetic-right and rotate-left shifts by any amount, and generalises the fixed left-shift-by-16 stage. Each clock cycle applies one barrel stage (shift by 2^k when bit k of the amount is set). A start/ready handshake lets the control unit stall on it like the multiplier/divider.

## Interface
Parameters:
- WIDTH, 32, data width in bits; power of two, at least 4.
- SHAMT_W, $clog2(WIDTH), shift-amount width and number of stages.

Ports:
- clock  in  1  rising-edge clock; the block's one clock.
- reset_n  in  1  reset, asynchronous, active-low.
- ctrl_start  in  1  request; sampled only when ready=1.
- ctrl_mode  in  2  operation: 00 SLL, 01 SRL, 10 SRA, 11 ROL.
- ctrl_shiftamt  in  SHAMT_W  shift amount, 0..WIDTH-1.
- data_operandA  in  WIDTH  operand to shift.
- ready  out  1  block can accept ctrl_start this cycle.
- data_resultRDY  out  1  one-cycle pulse: data_result is valid.
- data_result  out  WIDTH  shifted value; held until next accepted start.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE: ready=1. On ctrl_start=1:
  - latch data_operandA into the working register, and ctrl_mode and ctrl_shiftamt into internal registers;
  - clear the stage counter k to 0;
  - go to SHIFT.
- SHIFT: ready=0. Each cycle, if latched shamt bit k=1, shift the working register by 2^k per the latched mode; otherwise hold it.
  - Increment k each cycle.
  - After stage k=SHAMT_W-1, go to DONE.
- DONE: ready=1 and data_resultRDY=1 for exactly one cycle.
  - ctrl_start=1 in DONE is accepted exactly as in IDLE, giving back-to-back operations.
  - Otherwise go to IDLE.
- Fill rules per stage:
  - SLL fills zeros at the LSBs.
  - SRL fills zeros at the MSBs.
  - SRA replicates the current MSB; because the sign is preserved at every stage, the result is correct.
  - ROL wraps the MSBs into the LSBs.
- Latency is fixed regardless of amount. Shamt 0 still takes the full latency and returns the operand unchanged.
- ctrl_start=1 during SHIFT is ignored: no queueing and no effect on the operation in flight.
- Inputs are don't-care except in the cycle the start is accepted.
- data_result is the working register, driven directly. It changes during SHIFT and is meaningful only while data_resultRDY=1 or later in IDLE.

## Timing
- Reset (reset_n=0, asynchronous): state=IDLE, k=0, working register=0.
  - Outputs during and after reset: ready=1, data_resultRDY=0, data_result=0.
- Reset asserted mid-SHIFT aborts the operation immediately. No data_resultRDY pulse follows.
- Start accepted at edge E0. Stages are applied at edges E1..E_SHAMT_W.
- data_resultRDY is high in the cycle after edge E_SHAMT_W; for WIDTH=32 that is after E5.
  - Start-to-result latency is SHAMT_W+1 cycles, counting the accept cycle.
- ready is low from after E0 until after E_SHAMT_W.
- Back-to-back: a start in the DONE cycle begins the next operation at that edge. Maximum throughput is one result per SHAMT_W+1 cycles.
- All outputs are registered or decoded from registered state. No combinational path runs from inputs to outputs.

## Test plan
- Reset, then SLL 0x0000ABCD by 16 -> data_resultRDY pulses 6 cycles after the start cycle with data_result=0xABCD0000; ready returns to 1.
- SRA 0x80000000 by 31 -> 0xFFFFFFFF. SRL of the same operand by 31 -> 0x00000001. ROL 0x80000001 by 4 -> 0x00000018. Shamt 0 with mode SRA on 0x12345678 -> 0x12345678 after the full latency.
- Back-to-back: second start asserted in the DONE cycle (SRL 0xF0000000 by 8) -> its result 0x00F00000 arrives exactly 6 cycles after the first result pulse.
- Start asserted every cycle during SHIFT with a different operand -> ignored; the first result is uncorrupted and exactly one pulse appears per accepted start.
- reset_n pulled low at stage 2 of an operation -> outputs asynchronously return to ready=1, data_resultRDY=0, data_result=0; no pulse follows; a fresh start after release completes normally.
- Instance with WIDTH=8 (SHAMT_W=3): SRA 0x90 by 3 -> 0xF2; ROL 0x81 by 7 -> 0xC0; latency 4 cycles.
